// File: rtl/rsa_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer and its
// bit-serial Montgomery multiplier.
package rsa_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TO_MONT   = 3'd1,
      ST_LOOP_A    = 3'd2,
      ST_LOOP_B    = 3'd3,
      ST_FROM_MONT = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      MM_IDLE = 2'd0,
      MM_RUN  = 2'd1,
      MM_SUB  = 2'd2
   } mm_state_t;

   localparam logic MODE_LTR    = 1'b0;
   localparam logic MODE_LADDER = 1'b1;

   // Cycles a multiplication takes beyond its WIDTH serial iterations.
   localparam int MM_EXTRA_CYCLES = 2;

endpackage

// File: rtl/mont_mul_serial.sv
// Radix-2 bit-serial Montgomery multiplier: r = a*b*2^-WIDTH mod n, done pulses
// WIDTH+2 cycles after start (WIDTH iterations, then one conditional subtract).
module mont_mul_serial
   import rsa_pkg::*;
#(
   parameter int WIDTH = 1024
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic             done,
   output logic [WIDTH-1:0] r
);

   localparam int CNT_W = $clog2(WIDTH + MM_EXTRA_CYCLES);

   mm_state_t        state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] n_r;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH+1:0] acc_r;
   logic [CNT_W-1:0] cnt_r;
   logic             done_r;

   logic [WIDTH+1:0] sum_ab_s;
   logic [WIDTH+1:0] sum_abn_s;
   logic [WIDTH+1:0] acc_next_s;
   logic [WIDTH-1:0] acc_red_s;

   // One radix-2 step; the accumulator stays below 2N so WIDTH+2 bits suffice.
   always_comb begin
      if (a_r[0]) begin
         sum_ab_s = acc_r + {2'b00, b_r};
      end else begin
         sum_ab_s = acc_r;
      end
      if (sum_ab_s[0]) begin
         sum_abn_s = sum_ab_s + {2'b00, n_r};
      end else begin
         sum_abn_s = sum_ab_s;
      end
      acc_next_s = sum_abn_s >> 1;
      if (acc_r >= {2'b00, n_r}) begin
         acc_red_s = WIDTH'(acc_r - {2'b00, n_r});
      end else begin
         acc_red_s = acc_r[WIDTH-1:0];
      end
   end

   // Multiplier sequencing: latch operands, iterate, reduce, pulse done.
   always_ff @(posedge clk) begin
      if (resetn) begin
         state_r <= MM_IDLE;
         a_r     <= '0;
         b_r     <= '0;
         n_r     <= '0;
         r_r     <= '0;
         acc_r   <= '0;
         cnt_r   <= '0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            MM_IDLE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  n_r     <= n;
                  acc_r   <= '0;
                  cnt_r   <= '0;
                  state_r <= MM_RUN;
               end
            end
            MM_RUN: begin
               acc_r <= acc_next_s;
               a_r   <= a_r >> 1;
               cnt_r <= cnt_r + CNT_W'(1);
               if (cnt_r == CNT_W'(WIDTH - 1)) begin
                  state_r <= MM_SUB;
               end
            end
            MM_SUB: begin
               r_r     <= acc_red_s;
               done_r  <= 1'b1;
               state_r <= MM_IDLE;
            end
            default: state_r <= MM_IDLE;
         endcase
      end
   end

   assign done = done_r;
   assign r    = r_r;

endmodule

// File: rtl/rsa_modexp_seq.sv
// Modular-exponentiation sequencer: M^t mod N in the Montgomery domain, using
// left-to-right square-and-multiply or the constant-time Montgomery ladder.
module rsa_modexp_seq
   import rsa_pkg::*;
#(
   parameter int WIDTH     = 1024,
   parameter int EXP_WIDTH = 32,
   parameter int LEN_W     = 6
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     n_q,
   input  logic [WIDTH-1:0]     r_n_q,
   input  logic [WIDTH-1:0]     r2_n_q,
   input  logic [WIDTH-1:0]     m,
   input  logic [EXP_WIDTH-1:0] t,
   input  logic [LEN_W-1:0]     t_len,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     result
);

   state_t               state_r;
   logic                 mode_r;
   logic [WIDTH-1:0]     n_r;
   logic [WIDTH-1:0]     r2_n_r;
   logic [WIDTH-1:0]     m_r;
   logic [EXP_WIDTH-1:0] t_r;
   logic [LEN_W-1:0]     len_r;
   logic [LEN_W-1:0]     idx_r;
   logic [WIDTH-1:0]     a_r;
   logic [WIDTH-1:0]     x_r;
   logic                 mm_start_r;
   logic                 busy_r;
   logic                 done_r;
   logic [WIDTH-1:0]     result_r;

   logic [LEN_W-1:0]     len_s;
   logic                 cur_bit_s;
   logic                 last_bit_s;
   logic [WIDTH-1:0]     mm_a_s;
   logic [WIDTH-1:0]     mm_b_s;
   logic [WIDTH-1:0]     mm_r_s;
   logic                 mm_done_s;

   assign len_s      = (t_len > LEN_W'(EXP_WIDTH)) ? LEN_W'(EXP_WIDTH) : t_len;
   assign cur_bit_s  = |(t_r & (EXP_WIDTH'(1) << idx_r));
   assign last_bit_s = (idx_r == '0);

   // Operand select for the multiplication issued in the current state.
   always_comb begin
      mm_a_s = a_r;
      mm_b_s = a_r;
      case (state_r)
         ST_TO_MONT: begin
            mm_a_s = m_r;
            mm_b_s = r2_n_r;
         end
         ST_LOOP_A: begin
            if (mode_r == MODE_LADDER) begin
               mm_b_s = x_r;
            end else begin
               mm_b_s = a_r;
            end
         end
         ST_LOOP_B: begin
            if (mode_r == MODE_LTR) begin
               mm_b_s = x_r;
            end else if (cur_bit_s) begin
               mm_a_s = x_r;
               mm_b_s = x_r;
            end else begin
               mm_b_s = a_r;
            end
         end
         ST_FROM_MONT: mm_b_s = WIDTH'(1);
         default:      mm_b_s = a_r;
      endcase
   end

   mont_mul_serial #(
      .WIDTH (WIDTH)
   ) u_mm (
      .clk    (clk),
      .resetn (resetn),
      .start  (mm_start_r),
      .a      (mm_a_s),
      .b      (mm_b_s),
      .n      (n_r),
      .done   (mm_done_s),
      .r      (mm_r_s)
   );

   // Main sequencer; every transition into a multiplying state issues mm_start.
   always_ff @(posedge clk) begin
      if (resetn) begin
         state_r    <= ST_IDLE;
         mode_r     <= MODE_LTR;
         n_r        <= '0;
         r2_n_r     <= '0;
         m_r        <= '0;
         t_r        <= '0;
         len_r      <= '0;
         idx_r      <= '0;
         a_r        <= '0;
         x_r        <= '0;
         mm_start_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         result_r   <= '0;
      end else begin
         mm_start_r <= 1'b0;
         done_r     <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               busy_r <= 1'b0;
               if (start && !busy_r) begin
                  mode_r     <= mode;
                  n_r        <= n_q;
                  r2_n_r     <= r2_n_q;
                  m_r        <= m;
                  t_r        <= t;
                  len_r      <= len_s;
                  a_r        <= r_n_q;
                  busy_r     <= 1'b1;
                  mm_start_r <= 1'b1;
                  state_r    <= ST_TO_MONT;
               end
            end
            ST_TO_MONT: begin
               if (mm_done_s) begin
                  x_r        <= mm_r_s;
                  mm_start_r <= 1'b1;
                  if (len_r == '0) begin
                     state_r <= ST_FROM_MONT;
                  end else begin
                     idx_r   <= len_r - LEN_W'(1);
                     state_r <= ST_LOOP_A;
                  end
               end
            end
            ST_LOOP_A: begin
               if (mm_done_s) begin
                  mm_start_r <= 1'b1;
                  if (mode_r == MODE_LTR) begin
                     a_r <= mm_r_s;
                     if (cur_bit_s) begin
                        state_r <= ST_LOOP_B;
                     end else if (last_bit_s) begin
                        state_r <= ST_FROM_MONT;
                     end else begin
                        idx_r   <= idx_r - LEN_W'(1);
                        state_r <= ST_LOOP_A;
                     end
                  end else begin
                     if (cur_bit_s) begin
                        a_r <= mm_r_s;
                     end else begin
                        x_r <= mm_r_s;
                     end
                     state_r <= ST_LOOP_B;
                  end
               end
            end
            ST_LOOP_B: begin
               if (mm_done_s) begin
                  mm_start_r <= 1'b1;
                  if (mode_r == MODE_LADDER && cur_bit_s) begin
                     x_r <= mm_r_s;
                  end else begin
                     a_r <= mm_r_s;
                  end
                  if (last_bit_s) begin
                     state_r <= ST_FROM_MONT;
                  end else begin
                     idx_r   <= idx_r - LEN_W'(1);
                     state_r <= ST_LOOP_A;
                  end
               end
            end
            ST_FROM_MONT: begin
               if (mm_done_s) begin
                  a_r     <= mm_r_s;
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_r   <= 1'b1;
               result_r <= a_r;
               state_r  <= ST_IDLE;
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Self-checking bench: a plain-arithmetic model of M^t mod N and of the run
// timeline predicts busy/done/result every cycle; a few literal cases pin it.
module tb_rsa_modexp_seq;

   localparam int W    = 16;
   localparam int EW   = 32;
   localparam int LW   = 6;
   localparam int SLOT = W + 3;

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic          mode;
   logic [W-1:0]  n_q;
   logic [W-1:0]  r_n_q;
   logic [W-1:0]  r2_n_q;
   logic [W-1:0]  m;
   logic [EW-1:0] t;
   logic [LW-1:0] t_len;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;

   always #5 clk = ~clk;

   rsa_modexp_seq #(
      .WIDTH     (W),
      .EXP_WIDTH (EW),
      .LEN_W     (LW)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .mode   (mode),
      .n_q    (n_q),
      .r_n_q  (r_n_q),
      .r2_n_q (r2_n_q),
      .m      (m),
      .t      (t),
      .t_len  (t_len),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state, written only by the stimulus process.
   bit           chk_en    = 1'b0;
   bit           run_valid = 1'b0;
   bit           all_done  = 1'b0;
   int           ea        = 0;
   int           lat       = 0;
   logic [W-1:0] res_new   = '0;
   logic [W-1:0] res_old   = '0;
   int           hc_id     = 0;
   int           hc_lat    = 0;
   logic [W-1:0] hc_res    = '0;
   int           tmo_cnt   = 0;

   // Counters, written only by the compare process.
   int vectors     = 0;
   int miscompares = 0;
   int hc_done_id  = 0;

   function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [EW-1:0] e,
                                            input int l, input logic [W-1:0] nn);
      longint unsigned r;
      longint unsigned bb;
      longint unsigned nl;
      nl = 64'(nn);
      bb = 64'(b);
      r  = 64'd1 % nl;
      for (int i = l - 1; i >= 0; i--) begin
         r = (r * r) % nl;
         if (e[i]) r = (r * bb) % nl;
      end
      return r[W-1:0];
   endfunction

   function automatic int ref_lat(input bit md, input logic [EW-1:0] e, input int l);
      int pc;
      int k;
      pc = 0;
      for (int i = 0; i < l; i++) pc += int'(e[i]);
      k = md ? (2 + 2 * l) : (2 + l + pc);
      return 1 + k * SLOT;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Compare process: every cycle after reset, DUT outputs against the model.
   initial begin
      int           c;
      bit           eb;
      bit           ed;
      logic [W-1:0] er;
      forever begin
         @(negedge clk);
         if (all_done) begin
            chk("timeouts", 32'(tmo_cnt), 32'd0);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
         end
         if (chk_en) begin
            c  = cyc;
            eb = run_valid && (c >= ea) && (c <= ea + lat);
            ed = run_valid && (c == ea + lat);
            er = (run_valid && (c >= ea + lat)) ? res_new : res_old;
            chk("busy", 32'(busy), 32'(eb));
            chk("done", 32'(done), 32'(ed));
            chk("result", 32'(result), 32'(er));
            if (done && run_valid && (hc_id != hc_done_id)) begin
               hc_done_id = hc_id;
               chk("hand_result", 32'(result), 32'(hc_res));
               if (hc_lat > 0) chk("hand_latency", 32'(c - ea), 32'(hc_lat));
            end
         end
      end
   end

   task automatic run_op(input bit md, input logic [W-1:0] nn, input logic [W-1:0] mm,
                         input logic [EW-1:0] tt, input logic [LW-1:0] tl, input bit hand,
                         input logic [W-1:0] h_res, input int h_lat, input int poke_at,
                         input int rst_at);
      longint unsigned nl;
      longint unsigned rn;
      int              l;
      bit              got;
      nl = 64'(nn);
      rn = (64'd1 << W) % nl;
      l  = (tl > 6'd32) ? EW : int'(tl);
      @(negedge clk);
      #1;
      mode   = md;
      n_q    = nn;
      r_n_q  = W'(rn);
      r2_n_q = W'((rn * rn) % nl);
      m      = mm;
      t      = tt;
      t_len  = tl;
      start  = 1'b1;
      if (run_valid) res_old = res_new;
      run_valid = 1'b1;
      ea        = cyc + 1;
      lat       = ref_lat(md, tt, l);
      res_new   = ref_pow(mm, tt, l, nn);
      if (hand) begin
         hc_res = h_res;
         hc_lat = h_lat;
         hc_id++;
      end
      @(negedge clk);
      #1;
      start  = 1'b0;
      mode   = 1'($urandom);
      n_q    = W'($urandom);
      r_n_q  = W'($urandom);
      r2_n_q = W'($urandom);
      m      = W'($urandom);
      t      = $urandom;
      t_len  = LW'($urandom);
      got    = 1'b0;
      for (int k = 0; k < lat + 40 && !got; k++) begin
         start = (k == poke_at);
         if (k == rst_at) begin
            resetn    = 1'b1;
            run_valid = 1'b0;
            res_old   = '0;
            @(negedge clk);
            #1;
            resetn = 1'b0;
            got    = 1'b1;
         end else begin
            @(negedge clk);
            if (done) got = 1'b1;
            #1;
         end
      end
      start = 1'b0;
      if (!got) tmo_cnt++;
   endtask

   initial begin
      logic [W-1:0]  rn_n;
      logic [W-1:0]  rm;
      logic [EW-1:0] rt;
      resetn = 1'b1;
      start  = 1'b0;
      mode   = 1'b0;
      n_q    = '0;
      r_n_q  = '0;
      r2_n_q = '0;
      m      = '0;
      t      = '0;
      t_len  = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      #1;
      resetn = 1'b0;

      // Literal cases (W=16: one multiplier slot is 19 cycles).
      run_op(1'b0, 16'd13, 16'd2, 32'd5, 6'd3, 1'b1, 16'h0006, 134, -1, -1);
      run_op(1'b1, 16'd13, 16'd2, 32'd5, 6'd3, 1'b1, 16'h0006, 153, -1, -1);
      run_op(1'b1, 16'd13, 16'd2, 32'd3, 6'd3, 1'b1, 16'h0008, 153, -1, -1);
      run_op(1'b0, 16'hFFF1, 16'd3, 32'h10, 6'd5, 1'b1, 16'hFDB1, 153, -1, -1);
      run_op(1'b1, 16'hFFF1, 16'd3, 32'h10, 6'd5, 1'b1, 16'hFDB1, 229, -1, -1);
      run_op(1'b0, 16'd13, 16'd2, 32'd5, 6'd0, 1'b1, 16'h0001, 39, -1, -1);
      run_op(1'b1, 16'd13, 16'd2, 32'd5, 6'd0, 1'b1, 16'h0001, 39, -1, -1);
      run_op(1'b0, 16'd1, 16'd0, 32'd7, 6'd3, 1'b1, 16'h0000, 153, -1, -1);
      run_op(1'b0, 16'hFFF1, 16'd3, 32'hDEADBEEF, 6'd32, 1'b0, '0, 0, -1, -1);
      run_op(1'b0, 16'hFFF1, 16'd3, 32'hDEADBEEF, 6'd40, 1'b0, '0, 0, -1, -1);
      run_op(1'b1, 16'hFFFF, 16'hFFFE, 32'h8000_0001, 6'd40, 1'b0, '0, 0, -1, -1);
      // Start pulse while busy must be ignored.
      run_op(1'b0, 16'd13, 16'd2, 32'd5, 6'd3, 1'b1, 16'h0006, 134, 10, -1);
      // Reset during the first LOOP_A slot, then a clean run.
      run_op(1'b0, 16'hFFF1, 16'd3, 32'hFFFF, 6'd16, 1'b0, '0, 0, -1, 25);
      run_op(1'b1, 16'd13, 16'd2, 32'd5, 6'd3, 1'b1, 16'h0006, 153, -1, -1);

      for (int i = 0; i < 30; i++) begin
         rn_n = W'($urandom_range(1, 65535)) | 16'd1;
         rm   = W'($urandom_range(0, int'(rn_n) - 1));
         rt   = $urandom;
         run_op(1'($urandom), rn_n, rm, rt, LW'($urandom_range(0, 40)), 1'b0, '0, 0, -1, -1);
      end
      all_done = 1'b1;
   end

endmodule

// File: doc/rsa_modexp_seq.md
# rsa_modexp_seq

Parametrised modular-exponentiation sequencer: computes M^t mod N in the Montgomery domain by driving an internal bit-serial Montgomery multiplier, with selectable left-to-right square-and-multiply or constant-time Montgomery-ladder mode. It sits between the register/DMA front end of `rsa_hw` and the arithmetic datapath, and generalises the fixed 1024-bit engine to any operand width and exponent length.

## Interface
- `WIDTH`, 1024: operand/modulus width in bits; R = 2^WIDTH.
- `EXP_WIDTH`, 32: maximum exponent width in bits.
- `LEN_W`, 6: width of `t_len`; must satisfy 2^LEN_W > EXP_WIDTH.

Ports:
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: synchronous, active-high (1 = reset), sampled on `clk`.
- `start` in 1: request; accepted only when `busy`=0.
- `mode` in 1: 0 = left-to-right square-and-multiply, 1 = Montgomery ladder.
- `n_q` in WIDTH: modulus N, odd, N < 2^WIDTH.
- `r_n_q` in WIDTH: R mod N.
- `r2_n_q` in WIDTH: R² mod N.
- `m` in WIDTH: base, M < N.
- `t` in EXP_WIDTH: exponent.
- `t_len` in LEN_W: number of exponent bits used, t[t_len-1:0].
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle pulse, result valid.
- `result` out WIDTH: M^t mod N, held until the next accepted `start`.

## Operation
- Acceptance: `start`=1 and `busy`=0 → latch all operand inputs, `mode`, and clamped length L = min(t_len, EXP_WIDTH); inputs are ignored thereafter.
- `start` while `busy`=1 is ignored, with no queueing.
- MonMul(a,b) = a·b·R⁻¹ mod N, result in [0, N).
- States: IDLE → TO_MONT → LOOP_A → LOOP_B → FROM_MONT → DONE → IDLE.
- TO_MONT: X = MonMul(M, R2); A = R_N.
- Mode 0, per bit i = L-1 down to 0:
  - LOOP_A: A = MonMul(A, A).
  - LOOP_B: entered only if t[i]=1; A = MonMul(A, X).
- Mode 1, per bit i:
  - t[i]=1: LOOP_A A = MonMul(A, X); LOOP_B X = MonMul(X, X).
  - t[i]=0: LOOP_A X = MonMul(A, X); LOOP_B A = MonMul(A, A).
  - LOOP_B is always entered.
- FROM_MONT: result = MonMul(A, 1).
- DONE: `done`=1 for one cycle, then IDLE.
- L = 0: skip the loop; the result is 1 mod N (0 if N = 1).
- Bit index counter is LEN_W bits, decremented after LOOP_B (or after LOOP_A when LOOP_B is skipped); the loop exits when the decremented bit was bit 0, with no wrap past zero.
- Reset in any state: return to IDLE, abort the multiplier, `busy`=0, `done`=0, `result`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0.
- Multiplier slot: issue in the state-entry cycle; `mm_done` arrives WIDTH+2 cycles later; the controller registers the product and advances the next cycle. Each slot occupies exactly WIDTH+3 cycles.
- Latency from the acceptance edge to the `done` cycle: 1 + K·(WIDTH+3).
  - Mode 0: K = 2 + L + popcount(t[L-1:0]).
  - Mode 1: K = 2 + 2L (data-independent).
- `busy` falls in the cycle after `done`; a new `start` is accepted in that same cycle.
- `result` updates in the `done` cycle only.

## Structure
- Shared package `rsa_pkg`:
  - state enum.
  - `MODE_LTR` / `MODE_LADDER` constants.
  - `MM_EXTRA_CYCLES` = 2.
- Sub-module `mont_mul_serial`:
  - Ports: `clk`, `resetn`, `start`, `a`, `b`, `n`, `done`, `r`.
  - Radix-2: WIDTH iterations over an internal WIDTH+2-bit accumulator, then one conditional-subtract cycle.
  - `done` pulse at WIDTH+2 cycles after `start`.
  - Controller `resetn` aborts it.

## Test plan
- WIDTH=8, N=0x0D, R_N=0x09, R2=0x03, M=2, t=5, L=3, mode 0 → `result`=0x06, `done` 78 cycles after acceptance.
- Same operands with mode 1 → `result`=0x06 at 89 cycles; flipping t to 3 keeps 89 cycles, `result`=0x08.
- WIDTH=16, N=0xFFF1, R_N=0x000F, R2=0x00E1, M=3, t=0x10, L=5, both modes → `result`=0xFDB1.
- t_len=0 → `result`=0x01 after 1+2·(WIDTH+3) cycles; t_len=40 with EXP_WIDTH=32 → identical to t_len=32.
- `start` pulsed while `busy` → ignored, first result unchanged. Assert `resetn` mid-LOOP_A → next cycle `busy`=0, `result`=0; a fresh run then completes correctly.
- WIDTH=1024 regression with 200 random odd N and random M, t, `mode` → matches the software model bit-exact.
